// File: rtl/outbuf_deskew.sv
// Output-edge deskew buffer for the PE array: aligns skewed lane results into rows and
// queues them in a circular row FIFO drained over a valid/ready handshake.
module outbuf_deskew #(
  parameter int unsigned WORDLEN = 8,
  parameter int unsigned LANES   = 4,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [LANES-1:0]               lane_vld_i,
  input  logic [LANES*WORDLEN-1:0]       lane_dat_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [LANES*WORDLEN-1:0]       out_row_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           ovf_err_o,
  output logic                           skew_err_o,
  input  logic                           err_clr_i
);

  localparam int unsigned RowW = LANES * WORDLEN;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Aligned view of all lanes after deskew
  logic [LANES-1:0]              al_vld;
  logic [LANES-1:0][WORDLEN-1:0] al_dat;
  logic [RowW-1:0]               row_w;

  assign row_w = al_dat;

  // Lane i is delayed by LANES-1-i stages so every lane lines up with the last lane
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int unsigned NStg = LANES - 1 - g;
    if (NStg == 0) begin : g_pass
      assign al_vld[g] = lane_vld_i[g];
      assign al_dat[g] = lane_dat_i[g*WORDLEN +: WORDLEN];
    end else begin : g_dly
      logic [NStg-1:0]              vld_q, vld_d;
      logic [NStg-1:0][WORDLEN-1:0] dat_q, dat_d;

      // Shift chain next state: new sample enters stage 0
      always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = lane_vld_i[g];
        dat_d[0] = lane_dat_i[g*WORDLEN +: WORDLEN];
        for (int k = 1; k < int'(NStg); k++) begin
          vld_d[k] = vld_q[k-1];
          dat_d[k] = dat_q[k-1];
        end
      end

      // Deskew stage registers, cleared on reset
      always_ff @(posedge clk) begin
        if (!rstn) begin
          vld_q <= '0;
          dat_q <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign al_vld[g] = vld_q[NStg-1];
      assign al_dat[g] = dat_q[NStg-1];
    end
  end

  logic [RowW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic            ovf_q, ovf_d, skew_q, skew_d;
  logic            all_v, mixed_v, pop, push, ovf_set;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // FIFO control: push/pop decisions, pointer, count and sticky-flag next state
  always_comb begin
    all_v   = &al_vld;
    mixed_v = (|al_vld) & ~all_v;
    // Pop only when a head row already exists; out_ready on an empty FIFO is ignored
    pop     = ~empty_q & out_ready_i;
    // A full FIFO still accepts a row when the head leaves on the same edge
    push    = all_v & (~full_q | pop);
    ovf_set = all_v & full_q & ~pop;

    head_d  = pop  ? ptr_inc(head_q) : head_q;
    tail_d  = push ? ptr_inc(tail_q) : tail_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    full_d  = (count_d == CntW'(DEPTH));
    empty_d = (count_d == '0);

    // Setting wins over a simultaneous clear
    ovf_d  = ovf_set ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
    skew_d = mixed_v ? 1'b1 : (err_clr_i ? 1'b0 : skew_q);
  end

  // FIFO state and error flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      skew_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      skew_q  <= skew_d;
    end
  end

  // Row storage; contents are don't-care until written, gated by empty on read
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem_q[tail_q] <= row_w;
    end
  end

  assign out_valid_o = ~empty_q;
  assign out_row_o   = empty_q ? '0 : mem_q[head_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign ovf_err_o   = ovf_q;
  assign skew_err_o  = skew_q;

endmodule

// File: tb/tb_outbuf_deskew.sv
// Bench for outbuf_deskew: directed scenarios plus randomized rows, checked against a
// queue-based row model.
module tb_outbuf_deskew;

  localparam int W    = 8;
  localparam int L    = 4;
  localparam int D    = 4;
  localparam int PLEN = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  lane_vld = '0;
  logic [31:0] lane_dat = '0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        out_valid, full, empty, ovf_err, skew_err;
  logic [31:0] out_row;
  logic [2:0]  count;

  outbuf_deskew #(.WORDLEN(W), .LANES(L), .DEPTH(D)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .lane_vld_i (lane_vld),
    .lane_dat_i (lane_dat),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_row_o  (out_row),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .ovf_err_o  (ovf_err),
    .skew_err_o (skew_err),
    .err_clr_i  (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of rows plus a history of what each lane presented
  logic [31:0] q[$];
  bit          m_ovf, m_skew;
  logic [3:0]  hv[L];
  logic [31:0] hd[L];

  // Stimulus plan indexed by cycle
  logic [3:0]  plan_v[PLEN];
  logic [31:0] plan_d[PLEN];
  bit          plan_r[PLEN];
  bit          plan_c[PLEN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_row", out_row, (q.size() != 0) ? q[0] : 32'h0);
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("skew_err", 32'(skew_err), 32'(m_skew));
  endtask

  // Lane i word sampled at edge c belongs to the row completed at edge c+(L-1-i)
  task automatic model_edge();
    logic [3:0]  av;
    logic [31:0] ad;
    int          sz;
    bit          pop, ovf_s, skew_s;
    for (int k = L - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hd[k] = hd[k-1];
    end
    hv[0] = lane_vld;
    hd[0] = lane_dat;
    av = '0;
    ad = '0;
    for (int i = 0; i < L; i++) begin
      av[i]        = hv[L-1-i][i];
      ad[i*W +: W] = hd[L-1-i][i*W +: W];
    end
    sz     = q.size();
    pop    = (sz > 0) && out_ready;
    ovf_s  = 1'b0;
    skew_s = 1'b0;
    if (pop) void'(q.pop_front());
    if (av == 4'hF) begin
      if (sz < D || pop) q.push_back(ad);
      else ovf_s = 1'b1;
    end else if (av != 4'h0) begin
      skew_s = 1'b1;
    end
    m_ovf  = ovf_s  ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_skew = skew_s ? 1'b1 : (err_clr ? 1'b0 : m_skew);
  endtask

  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input bit r, input bit c);
    lane_vld  = v;
    lane_dat  = d;
    out_ready = r;
    err_clr   = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    lane_vld  = '0;
    lane_dat  = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    @(posedge clk);
    q.delete();
    m_ovf  = 1'b0;
    m_skew = 1'b0;
    for (int k = 0; k < L; k++) begin
      hv[k] = '0;
      hd[k] = '0;
    end
    #1;
    check_all();
    rstn = 1'b1;
  endtask

  task automatic clear_plan();
    for (int k = 0; k < PLEN; k++) begin
      plan_v[k] = '0;
      plan_d[k] = '0;
      plan_r[k] = 1'b0;
      plan_c[k] = 1'b0;
    end
  endtask

  task automatic set_ready(input int from, input int to, input bit r);
    for (int k = from; k <= to; k++) plan_r[k] = r;
  endtask

  // Schedule a skewed row starting at cycle t; skip drops a lane, late delays one lane a cycle
  task automatic add_row(input int t, input logic [31:0] d, input int skip, input int late);
    int ti;
    for (int i = 0; i < L; i++) begin
      if (i != skip) begin
        ti = t + i + ((i == late) ? 1 : 0);
        plan_v[ti][i]         = 1'b1;
        plan_d[ti][i*W +: W]  = d[i*W +: W];
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(plan_v[k], plan_d[k], plan_r[k], plan_c[k]);
  endtask

  initial begin
    logic [31:0] rd;
    do_reset();

    // 1: single skewed row, consumer always ready
    clear_plan();
    add_row(0, 32'h13121110, -1, -1);
    set_ready(0, 10, 1'b1);
    run(4);
    chk("t1_row", out_row, 32'h13121110);
    chk("t1_valid", 32'(out_valid), 32'd1);
    cycle('0, '0, 1'b1, 1'b0);
    chk("t1_valid_gone", 32'(out_valid), 32'd0);
    chk("t1_count", 32'(count), 32'd0);

    // 2: six back-to-back rows without draining
    do_reset();
    clear_plan();
    for (int n = 0; n < 6; n++) add_row(n, $urandom, -1, -1);
    run(10);
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ovf", 32'(ovf_err), 32'd1);
    for (int k = 0; k < 6; k++) cycle('0, '0, 1'b1, 1'b0);
    cycle('0, '0, 1'b0, 1'b1);
    chk("t2_ovf_clr", 32'(ovf_err), 32'd0);

    // 3: alternating push/pop with wrap
    do_reset();
    clear_plan();
    for (int n = 0; n < 10; n++) add_row(2 * n, {4{8'(n)}}, -1, -1);
    set_ready(0, PLEN - 1, 1'b1);
    run(26);

    // 4: full FIFO with a pop on the cycle a new row aligns
    do_reset();
    clear_plan();
    for (int n = 0; n < 4; n++) add_row(n, $urandom, -1, -1);
    add_row(8, 32'hA5A55A5A, -1, -1);
    plan_r[11] = 1'b1;
    run(12);
    chk("t4_count", 32'(count), 32'd4);
    chk("t4_ovf", 32'(ovf_err), 32'd0);
    for (int k = 0; k < 5; k++) cycle('0, '0, 1'b1, 1'b0);

    // 5: lane 2 one cycle late
    do_reset();
    clear_plan();
    add_row(0, 32'hDEADBEEF, -1, 2);
    run(6);
    chk("t5_skew", 32'(skew_err), 32'd1);
    chk("t5_count", 32'(count), 32'd0);
    cycle('0, '0, 1'b0, 1'b1);
    chk("t5_skew_clr", 32'(skew_err), 32'd0);

    // 6: reset while draining, with a partial row in flight
    do_reset();
    clear_plan();
    for (int n = 0; n < 3; n++) add_row(n, $urandom, -1, -1);
    add_row(5, $urandom, -1, -1);
    plan_r[6] = 1'b1;
    run(7);
    chk("t6_pre_count", 32'(count), 32'd2);
    do_reset();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_row", out_row, 32'h0);
    clear_plan();
    add_row(0, 32'h44332211, -1, -1);
    set_ready(0, 8, 1'b1);
    run(8);

    // Randomized rows, faults, back-pressure and clears
    do_reset();
    for (int b = 0; b < 4; b++) begin
      clear_plan();
      for (int t = 0; t < 56; t++) begin
        plan_r[t] = 1'($urandom_range(0, 2) != 0);
        plan_c[t] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 1) == 1) begin
          rd = $urandom;
          if ($urandom_range(0, 9) == 0) add_row(t, rd, $urandom_range(0, L - 1), -1);
          else add_row(t, rd, -1, -1);
        end
      end
      run(60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
